// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the multi-byte ALU sequencer.
// Request opcodes, ALU opcode constants and FSM states.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_EQ  = 2'b11
  } req_op_e;

  localparam logic [3:0] ALU_XOR = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_BEQ = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

  function automatic logic [3:0] alu_code(req_op_e op);
    unique case (op)
      OP_ADD:  alu_code = ALU_ADD;
      OP_SUB:  alu_code = ALU_SUB;
      OP_XOR:  alu_code = ALU_XOR;
      default: alu_code = ALU_BEQ;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: drives an 8-bit carry-chained ALU one byte per cycle.
// Optional whole-word zero/parity flags: define ALU_SEQ_FLAGS_EN.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [8*NBYTES-1:0] req_a,
  input  logic [8*NBYTES-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [8*NBYTES-1:0] rsp_data,
  output logic                rsp_eq,
  output logic                rsp_zero,
  output logic                rsp_par,
  output logic [3:0]          alu_op,
  output logic [2:0]          alu_imm,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  input  logic [7:0]          alu_rslt,
  input  logic                alu_zero,
  input  logic                alu_par,
  input  logic                alu_brc
);

  localparam int W = 8 * NBYTES;
  localparam logic [1:0] KLAST = 2'(NBYTES - 1);

  state_e       state_q, state_d;
  req_op_e      op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] data_q, data_d;
  logic [1:0]   k_q, k_d;
  logic         eq_q, eq_d;
  logic [3:0]   aop_q, aop_d;
  logic [7:0]   aa_q, aa_d;
  logic [7:0]   ab_q, ab_d;

  // Next-state: latch on accept, chain bytes in EXEC, hold in RESP.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    k_d     = k_q;
    eq_d    = eq_q;
    aop_d   = ALU_XOR;
    aa_d    = '0;
    ab_d    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_EXEC;
          op_d    = req_op_e'(req_op);
          a_d     = req_a;
          b_d     = req_b;
          data_d  = '0;
          k_d     = '0;
          eq_d    = (req_op_e'(req_op) == OP_EQ);
          aop_d   = alu_code(req_op_e'(req_op));
          aa_d    = req_a[7:0];
          ab_d    = req_b[7:0];
        end
      end
      S_EXEC: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (k_q == 2'(i) && op_q != OP_EQ)
            data_d[8*i +: 8] = alu_rslt;
        end
        eq_d = eq_q & ~alu_brc;
        k_d  = k_q + 2'd1;
        if (k_q == KLAST) begin
          state_d = S_RESP;
          k_d     = '0;
        end else begin
          aop_d = aop_q;
          for (int i = 0; i < NBYTES; i++) begin
            if (k_d == 2'(i)) begin
              aa_d = a_q[8*i +: 8];
              ab_d = b_q[8*i +: 8];
            end
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and registered ALU drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      k_q     <= '0;
      eq_q    <= 1'b0;
      aop_q   <= ALU_XOR;
      aa_q    <= '0;
      ab_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      k_q     <= k_d;
      eq_q    <= eq_d;
      aop_q   <= aop_d;
      aa_q    <= aa_d;
      ab_q    <= ab_d;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q, zero_d;
  logic par_q, par_d;

  // Whole-word zero/parity built from the per-byte ALU flags.
  always_comb begin
    zero_d = zero_q;
    par_d  = par_q;
    if (state_q == S_IDLE && req_valid) begin
      zero_d = (req_op_e'(req_op) != OP_EQ);
      par_d  = 1'b0;
    end else if (state_q == S_EXEC) begin
      zero_d = zero_q & alu_zero;
      par_d  = par_q ^ alu_par;
    end
  end

  // Flag accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b0;
      par_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      par_q  <= par_d;
    end
  end

  assign rsp_zero = zero_q;
  assign rsp_par  = par_q;
`else
  logic unused_flags;
  assign unused_flags = alu_zero ^ alu_par;
  assign rsp_zero = 1'b0;
  assign rsp_par  = 1'b0;
`endif

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = data_q;
  assign rsp_eq    = eq_q;
  assign alu_op    = aop_q;
  assign alu_imm   = 3'b000;
  assign alu_a     = aa_q;
  assign alu_b     = ab_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: sequencer plus a behavioural 8-bit ALU,
// checked against word-level arithmetic.
module tb_alu_seq_ctrl;

  localparam int N = 2;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_eq;
  logic         rsp_zero;
  logic         rsp_par;
  logic [3:0]   alu_op;
  logic [2:0]   alu_imm;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic [7:0]   alu_rslt;
  logic         alu_zero;
  logic         alu_par;
  logic         alu_brc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.NBYTES(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_eq    (rsp_eq),
    .rsp_zero  (rsp_zero),
    .rsp_par   (rsp_par),
    .alu_op    (alu_op),
    .alu_imm   (alu_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_rslt  (alu_rslt),
    .alu_zero  (alu_zero),
    .alu_par   (alu_par),
    .alu_brc   (alu_brc)
  );

  // Behavioural ALU with a registered carry/borrow.
  logic cy_q;
  logic co;
  always_comb begin
    alu_rslt = 8'h00;
    co       = 1'b0;
    case (alu_op)
      4'b0001: {co, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, cy_q};
      4'b0010: {co, alu_rslt} = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, cy_q};
      4'b0000: alu_rslt = alu_a ^ alu_b;
      default: alu_rslt = 8'h00;
    endcase
  end
  assign alu_zero = (alu_rslt == 8'h00);
  assign alu_par  = ^alu_rslt;
  assign alu_brc  = (alu_a != alu_b);

  always @(posedge clk) cy_q <= reset ? 1'b0 : co;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_model(input logic [1:0] op,
                                    input logic [W-1:0] a, b,
                                    output logic [W-1:0] d,
                                    output logic e, z, p);
    case (op)
      2'd0:    d = a + b;
      2'd1:    d = a - b;
      2'd2:    d = a ^ b;
      default: d = '0;
    endcase
    e = (op == 2'd3) && (a == b);
`ifdef ALU_SEQ_FLAGS_EN
    z = (op != 2'd3) && (d == '0);
    p = ^d;
`else
    z = 1'b0;
    p = 1'b0;
`endif
  endfunction

  function automatic logic [3:0] exp_code(input logic [1:0] op);
    case (op)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0000;
      default: return 4'b0111;
    endcase
  endfunction

  // One request/response transaction; called #1 after a posedge.
  task automatic do_req(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int stall);
    logic [W-1:0] ed;
    logic ee, ez, ep;
    logic [W-1:0] held;
    int n;
    ref_model(op, a, b, ed, ee, ez, ep);
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready_idle", req_ready, 1);
    check("alu_op_idle", alu_op, 0);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = W'($urandom);
    req_b = W'($urandom);
    check("req_ready_exec", req_ready, 0);
    check("alu_op_exec", alu_op, exp_code(op));
    check("alu_imm", alu_imm, 0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    rsp_ready = 1'b0;
    check("latency", n, N);
    check("rsp_data", rsp_data, ed);
    check("rsp_eq", rsp_eq, ee);
    check("rsp_zero", rsp_zero, ez);
    check("rsp_par", rsp_par, ep);
    held = rsp_data;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, held);
      check("stall_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("done_valid", rsp_valid, 0);
    check("done_ready", req_ready, 1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_op = 2'd0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_flags", {rsp_eq, rsp_zero, rsp_par}, 0);
    check("rst_alu", {alu_op, alu_imm, alu_a, alu_b}, 0);

    do_req(2'd0, 16'h12FF, 16'h0001, 0);
    do_req(2'd1, 16'h1000, 16'h0001, 1);
    do_req(2'd1, 16'h0000, 16'h0001, 0);
    do_req(2'd0, 16'h0001, 16'h0001, 0);
    do_req(2'd2, 16'hA5A5, 16'hFFFF, 0);
    do_req(2'd2, 16'h1234, 16'h1234, 0);
    do_req(2'd3, 16'hABCD, 16'hABCD, 0);
    do_req(2'd3, 16'hABCD, 16'hABCC, 0);
    do_req(2'd0, 16'hFFFF, 16'hFFFF, 3);

    req_valid = 1'b1;
    req_op = 2'd1;
    req_a = 16'h0000;
    req_b = 16'h0001;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_valid", rsp_valid, 0);
    check("abort_ready", req_ready, 1);
    check("abort_data", rsp_data, 0);
    check("abort_alu_op", alu_op, 0);
    do_req(2'd0, 16'h00FF, 16'h0001, 0);

    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] ra, rb;
      logic [1:0] rop;
      rop = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      do_req(rop, ra, rb, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
